crc8_frame_arbiter: RTL and testbench

Shares one CRC-8 framed byte link between NREQ trigger requesters. Grants the link round-robin and streams the granted requester's 8 payload bytes, then a computed CRC-8 byte, then two fill bytes: an 11-byte frame, CRC at index 8. Sits between the trigger sources and the serial transmitter, replacing per-source CRC streaming with one arbitrated, flow-controlled frame engine.

---
 rtl/crc8_frame_arbiter.sv | 177 +++++++++++++++++
 tb/tb_crc8_frame_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc8_frame_arbiter.sv
// crc8_frame_arbiter
//
// Round-robin arbiter and frame engine for a shared CRC-8 framed byte link.
// Each granted frame is 11 bytes long:
//   - bytes 0..7 are the payload, taken from the granted requester;
//   - byte 8 is the CRC-8 of those eight payload bytes;
//   - bytes 9..10 are FILL_BYTE.
// Output flow is valid/ready.
//
// Ports:
//   clk, reset      single clock; synchronous active-high reset
//   req_i           per-requester frame request (level)
//   pl_data_i       current payload byte of each requester, requester k on [8k+7:8k]
//   gnt_o           one-hot grant, held for the whole frame
//   pl_rd_o         pops one payload byte from the granted requester
//   byte_o          output byte
//   byte_valid_o    byte_o is valid
//   byte_ready_i    downstream accepts byte_o
//   sof_o / eof_o   frame byte 0 / frame byte 10 markers
//   byte_index_o    index of the current frame byte (0..10)
//   busy_o          a frame is in progress
//   frames_sent_o   completed frame count (wraps)
module crc8_frame_arbiter #(
  parameter int unsigned NREQ       = 4,
  parameter logic [7:0]  POLYNOMIAL = 8'h07,
  parameter logic [7:0]  INITIAL    = 8'hFF,
  parameter logic [7:0]  FILL_BYTE  = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_i,
  input  logic [8*NREQ-1:0] pl_data_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic              pl_rd_o,
  output logic [7:0]        byte_o,
  output logic              byte_valid_o,
  input  logic              byte_ready_i,
  output logic              sof_o,
  output logic              eof_o,
  output logic [3:0]        byte_index_o,
  output logic              busy_o,
  output logic [15:0]       frames_sent_o
);

  localparam int unsigned SelW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {StIdle, StPayload, StCrc, StFill} state_e;

  state_e          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [7:0]      crc_q, crc_d;
  logic [SelW-1:0] sel_q, sel_d;
  logic [SelW-1:0] last_q, last_d;
  logic [15:0]     frames_q, frames_d;

  logic [SelW-1:0] pick, cand;
  logic            found;
  logic [7:0]      pl_byte;
  logic            xfer;

  // MSB-first CRC-8, no reflection, no final XOR.
  function automatic logic [7:0] crc8_upd(input logic [7:0] c_in, input logic [7:0] b);
    logic [7:0] c;
    c = c_in ^ b;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ POLYNOMIAL) : (c << 1);
    end
    return c;
  endfunction

  // Round-robin search starting just above the last served requester.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = SelW'((32'(last_q) + i) % NREQ);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Payload byte of the granted requester.
  always_comb begin
    pl_byte = 8'h00;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (sel_q == SelW'(k)) pl_byte = pl_data_i[8*k +: 8];
    end
  end

  // Outputs
  always_comb begin
    busy_o        = (state_q != StIdle);
    byte_valid_o  = busy_o;
    xfer          = byte_valid_o & byte_ready_i;
    byte_index_o  = idx_q;
    sof_o         = byte_valid_o & (idx_q == 4'd0);
    eof_o         = byte_valid_o & (idx_q == 4'd10);
    pl_rd_o       = xfer & (state_q == StPayload);
    frames_sent_o = frames_q;
    gnt_o         = '0;
    if (busy_o) gnt_o[sel_q] = 1'b1;
    unique case (state_q)
      StPayload: byte_o = pl_byte;
      StCrc:     byte_o = crc_q;
      StFill:    byte_o = FILL_BYTE;
      default:   byte_o = 8'h00;
    endcase
  end

  // Next state
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    crc_d    = crc_q;
    sel_d    = sel_q;
    last_d   = last_q;
    frames_d = frames_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StPayload;
          sel_d   = pick;
          crc_d   = INITIAL;
          idx_d   = 4'd0;
        end
      end
      StPayload: begin
        if (xfer) begin
          crc_d = crc8_upd(crc_q, pl_byte);
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd7) state_d = StCrc;
        end
      end
      StCrc: begin
        if (xfer) begin
          idx_d   = 4'd9;
          state_d = StFill;
        end
      end
      StFill: begin
        if (xfer) begin
          if (idx_q == 4'd10) begin
            state_d  = StIdle;
            idx_d    = 4'd0;
            frames_d = frames_q + 16'd1;
            last_d   = sel_q;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      idx_q    <= 4'd0;
      crc_q    <= 8'h00;
      sel_q    <= '0;
      last_q   <= SelW'(NREQ - 1);
      frames_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      crc_q    <= crc_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      frames_q <= frames_d;
    end
  end

endmodule

// File: tb/tb_crc8_frame_arbiter.sv
// Scoreboard bench for crc8_frame_arbiter: expected frame bytes are queued when a
// frame is requested; a negedge monitor pops and compares on every accepted byte.
module tb_crc8_frame_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] pl_data;
  logic [3:0]  gnt;
  logic        pl_rd;
  logic [7:0]  byte_o;
  logic        byte_valid;
  logic        byte_ready;
  logic        sof, eof;
  logic [3:0]  byte_index;
  logic        busy;
  logic [15:0] frames;

  crc8_frame_arbiter #(
    .NREQ(4), .POLYNOMIAL(8'h07), .INITIAL(8'hFF), .FILL_BYTE(8'h00)
  ) dut (
    .clk(clk), .reset(reset), .req_i(req), .pl_data_i(pl_data), .gnt_o(gnt),
    .pl_rd_o(pl_rd), .byte_o(byte_o), .byte_valid_o(byte_valid),
    .byte_ready_i(byte_ready), .sof_o(sof), .eof_o(eof), .byte_index_o(byte_index),
    .busy_o(busy), .frames_sent_o(frames)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic [3:0] idx;
    logic [3:0] gnt;
  } exp_t;

  typedef struct {
    string       name;
    logic [63:0] act;
    logic [63:0] req;
  } chk_t;

  exp_t exp_q[$];
  chk_t chk_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Requester payload sources: each pops its next byte on pl_rd while granted.
  logic [7:0] pay [4][8];
  logic [3:0] ptr [4];
  int         rd_cnt [4];

  wire [63:0] outs = {27'b0, gnt, pl_rd, byte_o, byte_valid, sof, eof, byte_index, busy, frames};

  always_comb begin
    for (int k = 0; k < 4; k++) pl_data[8*k +: 8] = pay[k][ptr[k][2:0]];
  end

  initial begin
    for (int k = 0; k < 4; k++) begin
      ptr[k]    = 4'd0;
      rd_cnt[k] = 0;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 4; k++) begin
      if (!busy) ptr[k] <= 4'd0;
      else if (pl_rd && gnt[k]) begin
        ptr[k]    <= ptr[k] + 4'd1;
        rd_cnt[k] <= rd_cnt[k] + 1;
      end
    end
  end

  function automatic logic [7:0] model_crc(input logic [7:0] c_in, input logic [7:0] b);
    logic [7:0] c;
    c = c_in ^ b;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_t c;
    c.name = name;
    c.act  = act;
    c.req  = exp;
    chk_q.push_back(c);
  endtask

  // Queue the first nbytes of requester k's frame.
  task automatic push_frame(input int k, input bit use_hand, input logic [7:0] hand_crc,
                            input int nbytes);
    logic [7:0] c;
    exp_t       e;
    c = 8'hFF;
    for (int j = 0; j < 8; j++) c = model_crc(c, pay[k][j]);
    if (use_hand) c = hand_crc;
    for (int i = 0; i < nbytes; i++) begin
      e.idx = 4'(i);
      e.gnt = 4'b0001 << k;
      e.b   = (i < 8) ? pay[k][i] : ((i == 8) ? c : 8'h00);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle reached", {63'b0, busy}, 64'd0);
  endtask

  // Returns just after a rising edge with the given index on the output.
  task automatic wait_idx(input logic [3:0] i);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(byte_valid && byte_index == i) && n < 60);
    check("index reached", {60'b0, byte_index}, {60'b0, i});
  endtask

  task automatic stall(input logic [3:0] i);
    logic [7:0] hold_b;
    byte_ready = 1'b0;
    hold_b     = byte_o;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      check("stall hold", {50'b0, byte_o, byte_index, pl_rd, byte_valid},
            {50'b0, hold_b, i, 1'b0, 1'b1});
      @(posedge clk);
    end
    #1 byte_ready = 1'b1;
  endtask

  task automatic reset_pulse();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
  endtask

  // Monitor
  chk_t mc;
  exp_t me;
  always @(negedge clk) begin
    while (chk_q.size() > 0) begin
      mc = chk_q.pop_front();
      n_tests++;
      if (mc.act !== mc.req) begin
        n_fail++;
        $display("FAIL %s: got %0h, expected %0h", mc.name, mc.act, mc.req);
      end
    end
    if (byte_valid && byte_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected byte: got %0h at index %0d, expected none", byte_o, byte_index);
      end else begin
        me = exp_q.pop_front();
        if ({byte_o, byte_index, gnt, sof, eof, pl_rd} !==
            {me.b, me.idx, me.gnt, me.idx == 4'd0, me.idx == 4'd10, me.idx < 4'd8}) begin
          n_fail++;
          $display("FAIL frame byte: got b=%0h idx=%0d gnt=%b sof=%b eof=%b rd=%b, expected b=%0h idx=%0d gnt=%b",
                   byte_o, byte_index, gnt, sof, eof, pl_rd, me.b, me.idx, me.gnt);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  int rd0;
  int sof_cyc [4];
  int n;

  initial begin
    reset      = 1'b1;
    req        = 4'b0000;
    byte_ready = 1'b1;
    for (int k = 0; k < 4; k++) for (int j = 0; j < 8; j++) pay[k][j] = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle outputs", outs, 64'd0);
    end

    // Single frame of zeros: CRC 0xDB
    push_frame(0, 1'b1, 8'hDB, 11);
    rd0 = rd_cnt[0];
    req = 4'b0001;
    @(negedge clk);
    check("grant latency", {59'b0, gnt, sof}, {59'b0, 4'b0001, 1'b1});
    req = 4'b0000;
    wait_idle(30);
    check("payload pops", 64'(rd_cnt[0] - rd0), 64'd8);
    check("frames after one", {48'b0, frames}, 64'd1);

    // Round robin, back-to-back
    reset_pulse();
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 8; j++) pay[k][j] = 8'((k * 53) ^ (j * 29) ^ 8'hA5);
    for (int k = 0; k < 4; k++) push_frame(k, 1'b0, 8'h00, 11);
    req = 4'b1111;
    for (int f = 0; f < 4; f++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!sof && n < 40);
      check("sof seen", {63'b0, sof}, 64'd1);
      sof_cyc[f] = cyc;
    end
    req = 4'b0000;
    for (int f = 1; f < 4; f++) check("frame spacing", 64'(sof_cyc[f] - sof_cyc[f-1]), 64'd12);
    wait_idle(30);
    check("frames after rr", {48'b0, frames}, 64'd4);

    // Stalls at index 3 and index 8
    for (int j = 0; j < 8; j++) pay[2][j] = 8'(8'h3C + j * 17);
    push_frame(2, 1'b0, 8'h00, 11);
    @(negedge clk) req = 4'b0100;
    wait_idx(4'd3);
    req = 4'b0000;
    stall(4'd3);
    wait_idx(4'd8);
    stall(4'd8);
    wait_idle(30);

    // Reset mid-frame at index 5
    reset_pulse();
    for (int j = 0; j < 8; j++) pay[1][j] = 8'(8'hC1 ^ (j * 7));
    push_frame(1, 1'b0, 8'h00, 6);
    @(negedge clk) req = 4'b0010;
    wait_idx(4'd5);
    req   = 4'b0000;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset mid-frame", outs, 64'd0);
    reset = 1'b0;

    // Requester drops req mid-frame
    for (int j = 0; j < 8; j++) pay[2][j] = 8'(8'h90 + j);
    push_frame(2, 1'b0, 8'h00, 11);
    req = 4'b0100;
    @(negedge clk);
    check("grant after reset", {60'b0, gnt}, 64'b0100);
    wait_idx(4'd2);
    req = 4'b0000;
    wait_idle(30);
    check("frames after drop", {48'b0, frames}, 64'd1);

    // Frame counter wrap
    @(negedge clk);
    force dut.frames_q = 16'hFFFF;
    @(negedge clk);
    release dut.frames_q;
    check("frames preload", {48'b0, frames}, 64'hFFFF);
    for (int j = 0; j < 8; j++) pay[3][j] = 8'(8'hF0 - j * 3);
    push_frame(3, 1'b0, 8'h00, 11);
    req = 4'b1000;
    @(negedge clk);
    req = 4'b0000;
    wait_idle(30);
    check("frames wrap", {48'b0, frames}, 64'd0);

    n = 0;
    while (exp_q.size() > 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard drained", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
